// File: rtl/ina_i2c_master_if.sv
// ina_i2c_master_if: request/response bundle between a local controller and ina_i2c_master.
interface ina_i2c_master_if;
    logic        start;
    logic        rw;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_ptr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        nack;
    modport master (output start, rw, dev_addr, reg_ptr, wr_data, input rd_data, busy, done, nack);
    modport slave (input start, rw, dev_addr, reg_ptr, wr_data, output rd_data, busy, done, nack);
endinterface

// File: rtl/ina_i2c_master.sv
// ina_i2c_master: I2C master issuing single 16-bit register writes/reads to an INA-style slave.
module ina_i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    ina_i2c_master_if.slave bus,
    output logic            scl,
    inout  wire             sda
);
    typedef enum logic [4:0] {
        IDLE, START, ADDRW, ACK_A, PTR, ACK_P, WMSB, ACK_M, WLSB, ACK_L,
        RSTART, ADDRR, ACK_R, RMSB, MACK, RLSB, MNACK, STOP
    } state_t;
    state_t st, st_nx, succ;
    logic [7:0] qcnt, tx_byte, ptr_q;
    logic [1:0] q;
    logic [2:0] bitc;
    logic [6:0] addr_q;
    logic [15:0] wd_q, rx, rd_q;
    logic rw_q, smp, done_q, nack_q, sda_low, qend, bend, last, samp, byte_st, ack_st;
    assign qend = qcnt == 8'(CLK_DIV - 1);
    assign bend = qend && q == 2'd3;
    assign samp = q == 2'd2 && qcnt == 8'd0;
    assign byte_st = st inside {ADDRW, PTR, WMSB, WLSB, ADDRR, RMSB, RLSB};
    assign ack_st = st inside {ACK_A, ACK_P, ACK_M, ACK_L, ACK_R};
    assign last = bend && (bitc == 3'd0 || !byte_st);
    // Read bytes transmit all ones so the master leaves SDA released.
    assign tx_byte = st == ADDRW ? {addr_q, 1'b0} : st == PTR ? ptr_q : st == WMSB ? wd_q[15:8] :
                     st == WLSB ? wd_q[7:0] : st == ADDRR ? {addr_q, 1'b1} : 8'hff;
    assign sda = sda_low ? 1'b0 : 1'bz;
    assign bus.busy = st != IDLE;
    assign bus.done = done_q;
    assign bus.nack = nack_q;
    assign bus.rd_data = rd_q;
    always_comb begin
        succ = IDLE;
        scl = q == 2'd1 || q == 2'd2;
        sda_low = byte_st && !tx_byte[bitc];
        case (st)
            IDLE:    scl = 1'b1;
            START:   begin scl = q != 2'd3; sda_low = q[1]; succ = ADDRW; end
            ADDRW:   succ = ACK_A;
            ACK_A:   succ = PTR;
            PTR:     succ = ACK_P;
            ACK_P:   succ = rw_q ? RSTART : WMSB;
            WMSB:    succ = ACK_M;
            ACK_M:   succ = WLSB;
            WLSB:    succ = ACK_L;
            ACK_L:   succ = STOP;
            RSTART:  begin sda_low = q[1]; succ = ADDRR; end
            ADDRR:   succ = ACK_R;
            ACK_R:   succ = RMSB;
            RMSB:    succ = MACK;
            MACK:    begin sda_low = 1'b1; succ = RLSB; end
            RLSB:    succ = MNACK;
            MNACK:   succ = STOP;
            STOP:    begin scl = q != 2'd0; sda_low = !q[1]; succ = IDLE; end
            default: succ = IDLE;
        endcase
        st_nx = st == IDLE ? (bus.start ? START : IDLE) : !last ? st : (ack_st && smp) ? STOP : succ;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
            qcnt <= '0;
            q <= '0;
            bitc <= '0;
            rw_q <= 1'b0;
            addr_q <= '0;
            ptr_q <= '0;
            wd_q <= '0;
            rx <= '0;
            rd_q <= '0;
            smp <= 1'b0;
            done_q <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            st <= st_nx;
            done_q <= st == STOP && last;
            if (st == IDLE) begin
                qcnt <= '0;
                q <= '0;
                if (bus.start) begin
                    rw_q <= bus.rw;
                    addr_q <= bus.dev_addr;
                    ptr_q <= bus.reg_ptr;
                    wd_q <= bus.wr_data;
                    nack_q <= 1'b0;
                end
            end else begin
                qcnt <= qend ? '0 : qcnt + 8'd1;
                q <= qend ? q + 2'd1 : q;
                bitc <= last ? 3'd7 : bend ? bitc - 3'd1 : bitc;
                if (samp) smp <= sda;
                if (samp && (st == RMSB || st == RLSB)) rx <= {rx[14:0], sda};
                if (last && ack_st && smp) nack_q <= 1'b1;
                if (last && st == STOP && rw_q && !nack_q) rd_q <= rx;
            end
        end
    end
endmodule

// File: tb/tb_ina_i2c_master.sv
// tb_ina_i2c_master: drives two masters (CLK_DIV 4 and 1) against a behavioural I2C register
// slave and checks bus bytes, latency, status and read data against a register-file model.
module tb_ina_i2c_master;
    localparam logic [6:0] SLV = 7'h40;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic start_r = 1'b0;
    logic req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_ptr = '0;
    logic [15:0] req_data = '0;
    logic scl0, scl1, bscl, bsda, slv_low = 1'b0;
    logic busy_m, done_m, nack_m;
    logic [15:0] rd_m;
    wire sda0, sda1;
    int checks = 0, errors = 0;
    int pos = 0, nbyte = 0, n_start = 0, n_stop = 0, bi;
    logic addressed = 1'b0, rd_mode = 1'b0;
    logic [7:0] sh = '0, slv_ptr = '0;
    logic [15:0] data_in = '0, tw;
    logic [15:0] slv_mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] prev_rd [2];
    logic [7:0] obs[$];
    logic macks[$];
    always #5 clk = ~clk;
    ina_i2c_master_if if0 ();
    ina_i2c_master_if if1 ();
    ina_i2c_master #(.CLK_DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(if0), .scl(scl0), .sda(sda0));
    ina_i2c_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .scl(scl1), .sda(sda1));
    assign if0.start = start_r && !sel;
    assign if1.start = start_r && sel;
    assign if0.rw = req_rw;
    assign if1.rw = req_rw;
    assign if0.dev_addr = req_addr;
    assign if1.dev_addr = req_addr;
    assign if0.reg_ptr = req_ptr;
    assign if1.reg_ptr = req_ptr;
    assign if0.wr_data = req_data;
    assign if1.wr_data = req_data;
    assign busy_m = sel ? if1.busy : if0.busy;
    assign done_m = sel ? if1.done : if0.done;
    assign nack_m = sel ? if1.nack : if0.nack;
    assign rd_m = sel ? if1.rd_data : if0.rd_data;
    pullup (sda0);
    pullup (sda1);
    assign sda0 = (slv_low && !sel) ? 1'b0 : 1'bz;
    assign sda1 = (slv_low && sel) ? 1'b0 : 1'bz;
    assign bscl = sel ? scl1 : scl0;
    assign bsda = sel ? sda1 : sda0;
    // Behavioural slave: START/STOP detection, bit framing on SCL edges, register file.
    always @(negedge bsda) if (bscl === 1'b1) begin
        n_start++;
        pos = -1;
        nbyte = 0;
        addressed = 1'b0;
        rd_mode = 1'b0;
    end
    always @(posedge bsda) if (bscl === 1'b1) n_stop++;
    always @(posedge bscl) begin
        if (pos >= 0 && pos < 8) sh = {sh[6:0], bsda};
        else if (pos == 8 && rd_mode && nbyte > 0) macks.push_back(bsda);
    end
    always @(negedge bscl) begin
        pos++;
        if (pos == 8 && !(rd_mode && nbyte > 0)) begin
            obs.push_back(sh);
            if (nbyte == 0) begin
                addressed = sh[7:1] == SLV;
                rd_mode = sh[0];
            end else if (addressed && nbyte == 1) slv_ptr = sh;
            else if (addressed && nbyte == 2) data_in[15:8] = sh;
            else if (addressed && nbyte == 3) begin
                data_in[7:0] = sh;
                slv_mem[slv_ptr] = data_in;
            end
        end
        if (pos == 9) begin
            pos = 0;
            nbyte++;
        end
        tw = slv_mem[slv_ptr];
        bi = (nbyte == 1 ? 15 : 7) - pos;
        slv_low = !addressed ? 1'b0 : !(rd_mode && nbyte > 0) ? pos == 8 :
                  (nbyte < 3 && pos >= 0 && pos < 8) ? !tw[bi] : 1'b0;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic xact(input bit rw, input logic [6:0] a, input logic [7:0] p, input logic [15:0] d, input int again);
        int dv, lat, first, ndone, s;
        bit ok;
        logic [7:0] eb[$];
        s = sel ? 1 : 0;
        dv = sel ? 1 : 4;
        ok = a == SLV;
        lat = 1 + dv * (!ok ? 44 : rw ? 192 : 152);
        eb.push_back({a, 1'b0});
        if (ok) begin
            eb.push_back(p);
            if (rw) eb.push_back({a, 1'b1});
            else begin
                eb.push_back(d[15:8]);
                eb.push_back(d[7:0]);
            end
        end
        first = -1;
        ndone = 0;
        obs.delete();
        macks.delete();
        n_start = 0;
        n_stop = 0;
        @(negedge clk);
        req_rw = rw;
        req_addr = a;
        req_ptr = p;
        req_data = d;
        start_r = 1'b1;
        for (int c = 1; c <= lat + 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_r = 1'b0;
                chk("busy_on", 32'(busy_m), 1);
                chk("nack_clr", 32'(nack_m), 0);
            end
            if (c == again) begin
                start_r = 1'b1;
                req_rw = !rw;
                req_addr = 7'($urandom);
                req_ptr = 8'($urandom);
                req_data = 16'($urandom);
            end
            if (c == again + 1) start_r = 1'b0;
            if (done_m === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    chk("busy_at_done", 32'(busy_m), 0);
                end
            end
        end
        chk("latency", first, lat);
        chk("done_pulses", ndone, 1);
        chk("nack", 32'(nack_m), 32'(!ok));
        if (ok && !rw) ref_mem[p] = d;
        if (ok && rw) prev_rd[s] = ref_mem[p];
        chk("rd_data", 32'(rd_m), 32'(prev_rd[s]));
        chk("starts", n_start, (ok && rw) ? 2 : 1);
        chk("stops", n_stop, 1);
        chk("nbytes", obs.size(), eb.size());
        foreach (eb[i]) chk("byte", i < obs.size() ? 32'(obs[i]) : 32'hdead, 32'(eb[i]));
        if (ok && rw) chk("macks", macks.size() == 2 ? {30'd0, macks[0], macks[1]} : 32'hdead, 32'b01);
    endtask
    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 16'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl0), 1);
        chk("rst_sda", 32'(sda0), 1);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_done", 32'(if0.done), 0);
        chk("rst_nack", 32'(if0.nack), 0);
        chk("rst_rd", 32'(if0.rd_data), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        xact(1'b0, SLV, 8'h05, 16'hA1B2, 0);
        chk("slv_ptr", 32'(slv_ptr), 32'h05);
        chk("slv_data", 32'(data_in), 32'hA1B2);
        slv_mem[2] = 16'h1234;
        ref_mem[2] = 16'h1234;
        xact(1'b1, SLV, 8'h02, 16'h0000, 0);
        chk("rd_1234", 32'(if0.rd_data), 32'h1234);
        xact(1'b1, 7'h21, 8'h02, 16'h0000, 0);
        xact(1'b0, SLV, 8'h07, 16'h5A5A, 10);
        @(negedge clk);
        req_rw = 1'b0;
        req_addr = SLV;
        req_ptr = 8'h05;
        req_data = 16'hBEEF;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (229) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_scl", 32'(scl0), 1);
        chk("mid_rst_sda", 32'(sda0), 1);
        chk("mid_rst_busy", 32'(if0.busy), 0);
        chk("mid_rst_rd", 32'(if0.rd_data), 0);
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_scl", 32'(scl0), 1);
        xact(1'b0, SLV, 8'h03, 16'hC0DE, 0);
        for (int k = 0; k < 6; k++)
            xact(1'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV,
                 8'($urandom_range(0, 3)), 16'($urandom), 0);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        xact(1'b0, SLV, 8'h01, 16'($urandom), 0);
        xact(1'b1, SLV, 8'h01, 16'h0000, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
